inst_loader: RTL and testbench

- Writer side of the processor's program memory: takes 16-bit halfwords over a valid/ready stream and assembles them into 32-bit instructions.
- Writes each instruction into instruction memory at sequential addresses starting from 0.
- Holds the processor in reset while loading; releases it when the load completes.
- Sits between the host/debug port and the processor's inst_mem write port; its cpu_rst output drives the processor's sys_rst.

---
 rtl/inst_loader_if.sv | 24 ++
 rtl/inst_loader.sv | 143 ++++++++++++++
 tb/tb_inst_loader.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/inst_loader_if.sv
// rtl/inst_loader_if.sv - halfword stream and instruction memory write bus for inst_loader
interface inst_loader_if #(
    parameter int ADDR_W = 4
) ();
    logic              in_valid;
    logic [15:0]       in_data;
    logic              in_last;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    // Host side: drives the stream, observes the memory write port.
    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    // Loader side.
    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - assembles 16-bit halfwords into 32-bit instructions, writes program memory, gates cpu reset
module inst_loader #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              sys_rst,
    input  logic              start,
    inst_loader_if.slave      bus,
    output logic              cpu_rst,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RX_HI = 3'd1,
        RX_LO = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [15:0]       hi_q;
    logic              last_q;
    logic              in_ready_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              cpu_rst_q;
    logic              done_q;
    logic              err_q;
    logic [ADDR_W:0]   words_q;
    logic              beat;
    logic              restart;
    logic              at_top;

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign cpu_rst       = cpu_rst_q;
    assign done          = done_q;
    assign err           = err_q;
    assign words_loaded  = words_q;

    always_comb begin
        state_d = state_q;
        beat    = bus.in_valid && in_ready_q;
        restart = 1'b0;
        at_top  = (ptr_q == ADDR_W'(DEPTH - 1));
        case (state_q)
            IDLE: begin
                if (start) begin
                    restart = 1'b1;
                    state_d = RX_HI;
                end
            end
            RX_HI: begin
                if (beat) begin
                    state_d = bus.in_last ? DONE : RX_LO;
                end
            end
            RX_LO: begin
                if (beat) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (last_q || at_top) begin
                    state_d = DONE;
                end else begin
                    state_d = RX_HI;
                end
            end
            DONE: begin
                if (start) begin
                    restart = 1'b1;
                    state_d = RX_HI;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake and status outputs are registered from the next state so they
    // line up with the cycle the FSM actually occupies.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hi_q        <= '0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rst_q   <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            words_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == RX_HI) || (state_d == RX_LO);
            mem_we_q   <= (state_d == WRITE);
            cpu_rst_q  <= (state_d != DONE);
            done_q     <= (state_d == DONE);

            if (restart) begin
                ptr_q   <= '0;
                words_q <= '0;
                err_q   <= 1'b0;
            end

            if (state_q == RX_HI && beat) begin
                hi_q <= bus.in_data;
                if (bus.in_last) begin
                    err_q <= 1'b1;
                end
            end

            // Address and data are captured on the low beat and then held
            // untouched until the next instruction arrives.
            if (state_q == RX_LO && beat) begin
                last_q      <= bus.in_last;
                mem_addr_q  <= ptr_q;
                mem_wdata_q <= {hi_q, bus.in_data};
            end

            if (state_q == WRITE) begin
                ptr_q   <= ptr_q + ADDR_W'(1);
                words_q <= words_q + (ADDR_W + 1)'(1);
                if (!last_q && at_top) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - directed self-checking bench for inst_loader
module tb_inst_loader;

    logic       clk = 1'b0;
    logic       sys_rst;
    logic       start;
    logic       cpu_rst;
    logic       done;
    logic       err;
    logic [4:0] words_loaded;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int viol_cnt = 0;
    int base_wr;
    int base_viol;
    logic [31:0] tbmem [16];

    inst_loader_if #(.ADDR_W(4)) bus ();

    inst_loader #(.ADDR_W(4), .DEPTH(16)) dut (
        .clk          (clk),
        .sys_rst      (sys_rst),
        .start        (start),
        .bus          (bus.slave),
        .cpu_rst      (cpu_rst),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (bus.mem_we) begin
            wr_cnt = wr_cnt + 1;
            tbmem[bus.mem_addr] = bus.mem_wdata;
            if (bus.in_ready) viol_cnt = viol_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered and left on a falling edge; returns in the cycle after acceptance.
    task automatic beat(input logic [15:0] d, input logic last, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("beat_timeout", 32'(n), 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] hi, input logic [15:0] lo, input logic last,
                             input int gap, input int addr);
        beat(hi, 1'b0, gap);
        beat(lo, last, gap);
        chk("write_we", 32'(bus.mem_we), 32'd1);
        chk("write_addr", 32'(bus.mem_addr), 32'(addr));
        chk("write_data", bus.mem_wdata, {hi, lo});
        chk("write_ready_low", 32'(bus.in_ready), 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        sys_rst      = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        sys_rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(bus.in_ready), 32'd0);

        // Basic three-instruction load
        base_wr = wr_cnt;
        pulse_start();
        send_word(16'h0840, 16'h0005, 1'b0, 0, 0);
        send_word(16'h1040, 16'h0003, 1'b0, 0, 1);
        send_word(16'h1080, 16'h0000, 1'b1, 0, 2);
        @(negedge clk);
        chk("basic_done", 32'(done), 32'd1);
        chk("basic_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("basic_err", 32'(err), 32'd0);
        chk("basic_words", 32'(words_loaded), 32'd3);
        chk("basic_ready", 32'(bus.in_ready), 32'd0);
        chk("basic_mem0", tbmem[0], 32'h08400005);
        chk("basic_mem1", tbmem[1], 32'h10400003);
        chk("basic_mem2", tbmem[2], 32'h10800000);
        chk("basic_wr_cnt", 32'(wr_cnt - base_wr), 32'd3);

        // Same stream with host gaps; restart from DONE
        base_viol = viol_cnt;
        pulse_start();
        chk("restart_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("restart_done", 32'(done), 32'd0);
        beat(16'h0840, 1'b0, 3);
        beat(16'h0005, 1'b0, 5);
        chk("gap_we0", 32'(bus.mem_we), 32'd1);
        chk("gap_data0", bus.mem_wdata, 32'h08400005);
        send_word(16'h1040, 16'h0003, 1'b0, 2, 1);
        beat(16'h1080, 1'b0, 4);
        beat(16'h0000, 1'b1, 1);
        chk("gap_we2", 32'(bus.mem_we), 32'd1);
        chk("gap_addr2", 32'(bus.mem_addr), 32'd2);
        chk("gap_data2", bus.mem_wdata, 32'h10800000);
        @(negedge clk);
        chk("gap_done", 32'(done), 32'd1);
        chk("gap_words", 32'(words_loaded), 32'd3);
        chk("gap_ready_viol", 32'(viol_cnt - base_viol), 32'd0);

        // Full memory with last on the 16th instruction
        pulse_start();
        for (int i = 0; i < 16; i++)
            send_word(16'(16'hA000 + i), 16'(16'h5000 + i), (i == 15), 0, i);
        @(negedge clk);
        chk("fullA_done", 32'(done), 32'd1);
        chk("fullA_err", 32'(err), 32'd0);
        chk("fullA_words", 32'(words_loaded), 32'd16);
        chk("fullA_mem15", tbmem[15], 32'hA00F500F);

        // Full memory without last: truncated
        base_wr = wr_cnt;
        pulse_start();
        for (int i = 0; i < 16; i++)
            send_word(16'(16'hB000 + i), 16'(16'hC000 + i), 1'b0, 0, i);
        @(negedge clk);
        chk("fullB_done", 32'(done), 32'd1);
        chk("fullB_err", 32'(err), 32'd1);
        chk("fullB_words", 32'(words_loaded), 32'd16);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hDEAD;
        repeat (4) @(negedge clk);
        bus.in_valid = 1'b0;
        chk("fullB_ready", 32'(bus.in_ready), 32'd0);
        chk("fullB_wr_cnt", 32'(wr_cnt - base_wr), 32'd16);
        chk("fullB_mem0", tbmem[0], 32'hB000C000);

        // Last flag on a high half
        base_wr = wr_cnt;
        pulse_start();
        chk("hilast_err_cleared", 32'(err), 32'd0);
        send_word(16'h1111, 16'h2222, 1'b0, 0, 0);
        beat(16'h3333, 1'b1, 0);
        chk("hilast_done", 32'(done), 32'd1);
        chk("hilast_err", 32'(err), 32'd1);
        chk("hilast_words", 32'(words_loaded), 32'd1);
        chk("hilast_we", 32'(bus.mem_we), 32'd0);
        repeat (2) @(negedge clk);
        chk("hilast_wr_cnt", 32'(wr_cnt - base_wr), 32'd1);

        // Reset in the middle of instruction 3
        base_wr = wr_cnt;
        pulse_start();
        send_word(16'h4444, 16'h0001, 1'b0, 0, 0);
        send_word(16'h4444, 16'h0002, 1'b0, 0, 1);
        beat(16'h4444, 1'b0, 0);
        chk("midrst_pre_ready", 32'(bus.in_ready), 32'd1);
        sys_rst = 1'b1;
        @(negedge clk);
        sys_rst = 1'b0;
        chk("midrst_ready", 32'(bus.in_ready), 32'd0);
        chk("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_words", 32'(words_loaded), 32'd0);
        chk("midrst_we", 32'(bus.mem_we), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0003;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        chk("midrst_idle_ready", 32'(bus.in_ready), 32'd0);
        chk("midrst_wr_cnt", 32'(wr_cnt - base_wr), 32'd2);
        pulse_start();
        send_word(16'h5555, 16'h6666, 1'b1, 0, 0);
        @(negedge clk);
        chk("midrst_reload_done", 32'(done), 32'd1);
        chk("midrst_reload_words", 32'(words_loaded), 32'd1);

        // Start in DONE restarts; start in RX_LO is ignored
        pulse_start();
        chk("dstart_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("dstart_done", 32'(done), 32'd0);
        beat(16'h7777, 1'b0, 0);
        pulse_start();
        chk("lostart_ready", 32'(bus.in_ready), 32'd1);
        chk("lostart_cpu_rst", 32'(cpu_rst), 32'd1);
        beat(16'h8888, 1'b0, 0);
        chk("lostart_we", 32'(bus.mem_we), 32'd1);
        chk("lostart_addr", 32'(bus.mem_addr), 32'd0);
        chk("lostart_data", bus.mem_wdata, 32'h77778888);
        send_word(16'h9999, 16'hAAAA, 1'b1, 0, 1);
        @(negedge clk);
        chk("two_done", 32'(done), 32'd1);
        chk("two_err", 32'(err), 32'd0);
        chk("two_words", 32'(words_loaded), 32'd2);
        chk("two_cpu_rst", 32'(cpu_rst), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
